// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the IMEM boot loader.
// Build option IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEF      = 256;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream input and IMEM write port of the loader.
// master = loader side, slave = stream source / IMEM side.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;

  modport master (
    input  byte_i, byte_valid_i,
    output byte_ready_o, we_o, waddr_o, wdata_o
  );

  modport slave (
    output byte_i, byte_valid_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs bytes little-endian into a 32-bit word.
// full_o flags the cycle in which the last byte of a word is loaded.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        load_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [1:0]  cnt;
  logic [31:0] word;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear_i) begin
      cnt  <= '0;
      word <= '0;
    end else if (load_i) begin
      word[{cnt, 3'b000} +: 8] <= byte_i;
      cnt <= cnt + 2'd1;
    end
  end

  assign word_o = word;
  assign full_o = load_i && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte stream to IMEM word loader; holds the CPU via busy_o.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailer check and csum_o.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  imem_loader_if.master    bus,
  output logic             busy_o,
  output logic             done_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]      csum_o,
`endif
  output logic             err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e LAST_ST = S_CHECK;
  logic [31:0] csum;
`else
  localparam state_e LAST_ST = S_DONE;
`endif

  state_e           state, next;
  logic [LEN_W-1:0] len_q, word_cnt;
  logic [31:0]      waddr, wdata;
  logic             err;
  logic             ready, we, busy, done;
  logic             asm_clear, asm_load, asm_full;
  logic [31:0]      asm_word, asm_next;
  logic             over_len;

  assign over_len = 32'(len_i) > 32'(DEPTH);
  assign asm_load = ready && bus.byte_valid_i;
  // Word including the byte being accepted this cycle.
  assign asm_next = {bus.byte_i, asm_word[23:0]};

  word_assembler u_asm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(asm_clear),
    .byte_i (bus.byte_i),
    .load_i (asm_load),
    .word_o (asm_word),
    .full_o (asm_full)
  );

  always_comb begin
    next      = state;
    ready     = 1'b0;
    we        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    asm_clear = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_i) begin
          asm_clear = 1'b1;
          if (len_i == '0) next = LAST_ST;
          else if (!over_len) next = S_RECV;
        end
      end
      S_RECV: begin
        ready = 1'b1;
        if (asm_full) next = S_WRITE;
      end
      S_WRITE: begin
        we = 1'b1;
        if (word_cnt + 1'b1 == len_q) next = LAST_ST;
        else next = S_RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        ready = 1'b1;
        if (asm_full) next = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      waddr    <= '0;
      wdata    <= '0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state <= next;
      if (state == S_IDLE && start_i) begin
        len_q    <= len_i;
        word_cnt <= '0;
        err      <= over_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      // Address and data latch here and hold until the next word.
      if (state == S_RECV && asm_full) begin
        waddr <= {{(30 - LEN_W){1'b0}}, word_cnt, 2'b00};
        wdata <= asm_next;
      end
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= csum + wdata;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == S_CHECK && asm_full && asm_next != csum) err <= 1'b1;
`endif
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.we_o         = we;
  assign bus.waddr_o      = waddr;
  assign bus.wdata_o      = wdata;
  assign busy_o           = busy;
  assign done_o           = done;
  assign err_o            = err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign csum_o           = csum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed plus randomized checks of imem_loader
// against a byte-list reference model.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy, done, err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .len_i  (len),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .csum_o (csum),
`endif
    .err_o  (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wlog[$];
  int          dlog[$];
  int          cyc = 0;
  logic [7:0]  bq[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_sum;
  bit          bad_trailer = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (bus.we_o === 1'b1) wlog.push_back('{bus.waddr_o, bus.wdata_o, cyc});
    if (done === 1'b1) dlog.push_back(cyc);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: every 4 bytes form one little-endian word.
  task automatic make_bytes(input int nwords);
    bq.delete();
    exp_w.delete();
    exp_sum = '0;
    for (int i = 0; i < nwords * 4; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < nwords; i++) begin
      exp_w.push_back({bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]});
      exp_sum = exp_sum + exp_w[i];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      bus.byte_valid_i = 1'b0;
      tick();
    end
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    n = 0;
    while (bus.byte_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", bus.byte_ready_o, 32'd1);
    tick();
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic begin_load(input int l);
    wlog.delete();
    dlog.delete();
    start = 1'b1;
    len = 16'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++)
      send_byte(bq[i], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
  endtask

  task automatic finish_load();
    int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] t;
    t = bad_trailer ? 32'h0 : exp_sum;
    for (int k = 0; k < 4; k++) send_byte(t[8*k +: 8], 0);
`endif
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("done_pulse", done, 32'd1);
    tick();
  endtask

  task automatic verify(input string tag);
    check({tag, "_nwr"}, wlog.size(), exp_w.size());
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++) begin
      check({tag, "_addr"}, wlog[i].addr, 32'(i * 4));
      check({tag, "_data"}, wlog[i].data, exp_w[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.byte_ready_o, 32'd0);
    check({tag, "_we"}, bus.we_o, 32'd0);
    check({tag, "_waddr"}, bus.waddr_o, 32'd0);
    check({tag, "_wdata"}, bus.wdata_o, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_done"}, done, 32'd0);
    check({tag, "_err"}, err, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, csum, 32'd0);
`endif
  endtask

  initial begin
    bus.byte_i = '0;
    bus.byte_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Directed two-word load, back-to-back bytes.
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_w = '{32'h12345678, 32'hDEADBEEF};
    exp_sum = exp_w[0] + exp_w[1];
    begin_load(2);
    check("t1_busy", busy, 32'd1);
    check("t1_ready", bus.byte_ready_o, 32'd1);
    stream(0, 7, 0);
    finish_load();
    verify("t1");
    if (wlog.size() >= 2) check("t1_spacing", wlog[1].cyc - wlog[0].cyc, 32'd5);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (wlog.size() >= 2 && dlog.size() >= 1)
      check("t1_done_lat", dlog[0] - wlog[1].cyc, 32'd1);
`endif
    check("t1_idle", busy, 32'd0);
    check("t1_err", err, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Same load with a wrong trailer.
    bad_trailer = 1'b1;
    begin_load(2);
    stream(0, 7, 0);
    finish_load();
    bad_trailer = 1'b0;
    check("cs_bad_err", err, 32'd1);
    check("cs_bad_dlog", dlog.size(), 32'd1);
`endif

    // Stall three cycles between bytes 1 and 2.
    make_bytes(1);
    begin_load(1);
    stream(0, 1, 0);
    repeat (3) begin
      check("stall_ready", bus.byte_ready_o, 32'd1);
      tick();
    end
    stream(2, 3, 0);
    finish_load();
    verify("stall");

    // Over-length request is rejected.
    begin_load(DEPTH + 1);
    check("ovl_err", err, 32'd1);
    check("ovl_busy", busy, 32'd0);
    check("ovl_done", done, 32'd0);
    repeat (3) tick();
    check("ovl_nwr", wlog.size(), 32'd0);
    check("ovl_ndone", dlog.size(), 32'd0);
    make_bytes(1);
    begin_load(1);
    check("ovl_clr", err, 32'd0);
    stream(0, 3, 1);
    finish_load();
    verify("ovl_next");

    // Reset mid-word.
    make_bytes(1);
    begin_load(1);
    stream(0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_nwr", wlog.size(), 32'd0);
    make_bytes(1);
    begin_load(1);
    stream(0, 3, 0);
    finish_load();
    verify("postrst");

    // start while busy is ignored.
    make_bytes(3);
    begin_load(3);
    stream(0, 4, 0);
    start = 1'b1;
    len = 16'd1;
    tick();
    start = 1'b0;
    stream(5, 11, 0);
    finish_load();
    verify("restart");

    // Zero-length load.
    exp_w.delete();
    exp_sum = '0;
    begin_load(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("z_done", done, 32'd1);
    check("z_busy", busy, 32'd1);
    tick();
    check("z_idle", busy, 32'd0);
`else
    check("z_busy", busy, 32'd1);
    finish_load();
    check("z_err", err, 32'd0);
`endif
    check("z_nwr", wlog.size(), 32'd0);

    // Randomized loads with random stalls.
    for (int it = 0; it < 5; it++) begin
      make_bytes($urandom_range(6, 1));
      begin_load(exp_w.size());
      stream(0, bq.size() - 1, 2);
      finish_load();
      verify("rand");
      check("rand_err", err, 32'd0);
    end

    // Full-capacity load.
    make_bytes(DEPTH);
    begin_load(DEPTH);
    stream(0, bq.size() - 1, 0);
    finish_load();
    verify("full");
    check("full_err", err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
